// File: rtl/mac_operand_sequencer_if.sv
// Bus between the operand sequencer and its environment: job control, the shared
// operand-buffer read port, and the operand/control outputs that feed the DSP MAC.
interface mac_operand_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic [ADDR_W:0]   vec_len_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              stall_i;
  logic              buf_rd_o;
  logic [ADDR_W-1:0] buf_addr_o;
  logic signed [7:0] in_data_i;
  logic signed [7:0] wt_data_i;
  logic              dsp_enable_o;
  logic signed [7:0] dsp_input_o;
  logic signed [7:0] dsp_weight_o;
  logic              clear_o;
  logic              dsp_valid_o;
  logic              busy_o;
  logic              done_o;

  // The master side is the job requester together with the operand buffers.
  modport master (
    output start_i, vec_len_i, base_addr_i, stall_i, in_data_i, wt_data_i,
    input  buf_rd_o, buf_addr_o, dsp_enable_o, dsp_input_o, dsp_weight_o,
           clear_o, dsp_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, vec_len_i, base_addr_i, stall_i, in_data_i, wt_data_i,
    output buf_rd_o, buf_addr_o, dsp_enable_o, dsp_input_o, dsp_weight_o,
           clear_o, dsp_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Control stage ahead of the DSP MAC: clears the accumulator, streams vec_len operand
// pairs out of the input/weight buffers, then waits out the DSP latency and flags the result.
module mac_operand_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DSP_LAT = 3,
  parameter int ACC_II  = 1
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  mac_operand_sequencer_if.slave bus
);

  localparam int DRAIN_W = $clog2(DSP_LAT + 2);
  localparam int II_W    = (ACC_II > 1) ? $clog2(ACC_II) : 1;

  localparam logic [ADDR_W:0]    K_ONE      = 1;
  localparam logic [II_W-1:0]    II_ONE     = 1;
  localparam logic [II_W-1:0]    II_RELOAD  = II_W'(ACC_II - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DSP_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_k;
  logic [ADDR_W-1:0] r_base;
  logic [II_W-1:0]   r_iiCnt;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic              r_rdDly;
  logic              r_enable;
  logic signed [7:0] r_input;
  logic signed [7:0] r_weight;
  logic              w_rd;
  logic              w_lenZero;

  assign w_lenZero = (r_len == '0);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_nextState = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_nextState = w_lenZero ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        // A read slot opens once the accumulate interval has elapsed; a stall only defers it.
        w_rd = !bus.stall_i && (r_iiCnt == '0);
        if (w_rd && (r_k == r_len - K_ONE)) begin
          w_nextState = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drainCnt == DRAIN_LAST) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_len      <= '0;
      r_base     <= '0;
      r_k        <= '0;
      r_iiCnt    <= '0;
      r_drainCnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start_i) begin
        r_len  <= bus.vec_len_i;
        r_base <= bus.base_addr_i;
        r_k    <= '0;
      end
      if (r_state == S_ISSUE) begin
        if (w_rd) begin
          r_k     <= r_k + K_ONE;
          r_iiCnt <= II_RELOAD;
        end else if (r_iiCnt != '0) begin
          r_iiCnt <= r_iiCnt - II_ONE;
        end
      end else begin
        r_iiCnt <= '0;
      end
      // Drain spans the two pipeline stages plus the DSP latency after the last read.
      r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + DRAIN_ONE : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rdDly  <= 1'b0;
      r_enable <= 1'b0;
      r_input  <= '0;
      r_weight <= '0;
    end else begin
      r_rdDly  <= w_rd;
      r_enable <= r_rdDly;
      if (r_rdDly) begin
        r_input  <= bus.in_data_i;
        r_weight <= bus.wt_data_i;
      end
    end
  end

  assign bus.buf_rd_o     = w_rd;
  assign bus.buf_addr_o   = r_base + r_k[ADDR_W-1:0];
  assign bus.dsp_enable_o = r_enable;
  assign bus.dsp_input_o  = r_input;
  assign bus.dsp_weight_o = r_weight;
  assign bus.clear_o      = (r_state == S_CLEAR);
  assign bus.dsp_valid_o  = (r_state == S_DONE) && !w_lenZero;
  assign bus.done_o       = (r_state == S_DONE);
  assign bus.busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer: two instances (ACC_II=1 and ACC_II=2) with
// behavioural operand buffers and a behavioural MAC accumulating what the sequencer streams out.
module tb_mac_operand_sequencer;

  localparam int ADDR_W  = 8;
  localparam int DSP_LAT = 3;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  mac_operand_sequencer_if #(.ADDR_W(ADDR_W)) ifA ();
  mac_operand_sequencer_if #(.ADDR_W(ADDR_W)) ifB ();

  mac_operand_sequencer #(.ADDR_W(ADDR_W), .DSP_LAT(DSP_LAT), .ACC_II(1)) dutA (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifA)
  );

  mac_operand_sequencer #(.ADDR_W(ADDR_W), .DSP_LAT(DSP_LAT), .ACC_II(2)) dutB (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifB)
  );

  logic signed [7:0] inMem [0:255];
  logic signed [7:0] wtMem [0:255];

  // Single-port operand buffers: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (ifA.buf_rd_o) begin
      ifA.in_data_i <= inMem[ifA.buf_addr_o];
      ifA.wt_data_i <= wtMem[ifA.buf_addr_o];
    end
    if (ifB.buf_rd_o) begin
      ifB.in_data_i <= inMem[ifB.buf_addr_o];
      ifB.wt_data_i <= wtMem[ifB.buf_addr_o];
    end
  end

  int total = 0;
  int bad   = 0;

  int clearCnt, clearCyc, rdCnt, firstRd, lastRd, rdB2B;
  int enCnt, firstEn, lastEn, maxGap, holdErr;
  int validCnt, validCyc, macOut, doneCnt, doneCyc, busyCnt, timedOut;
  int addrQ[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic driveJob(input bit selB, input bit start, input int len, input int base);
    if (selB) begin
      ifB.start_i     = start;
      ifB.vec_len_i   = len[ADDR_W:0];
      ifB.base_addr_i = base[ADDR_W-1:0];
    end else begin
      ifA.start_i     = start;
      ifA.vec_len_i   = len[ADDR_W:0];
      ifA.base_addr_i = base[ADDR_W-1:0];
    end
  endtask

  task automatic driveStall(input bit s);
    ifA.stall_i = s;
    ifB.stall_i = s;
  endtask

  function automatic int addrAt(input int i);
    return (i < addrQ.size()) ? addrQ[i] : -1;
  endfunction

  // Runs one job; cycle 0 is the cycle start_i is presented. Records events until 10 cycles after done.
  task automatic applyStimulus(input bit selB, input int len, input int base,
                               input int stallAfter, input int stallLen, input int pulseAt);
    int cyc, trail, stallLeft, acc, inV, wtV, lastIn, lastWt, addr;
    logic rd, en, clr, val, dn, bsy, prevRd;
    bit seenDone;
    clearCnt = 0; clearCyc = -1; rdCnt = 0; firstRd = -1; lastRd = -1; rdB2B = 0;
    enCnt = 0; firstEn = -1; lastEn = -1; maxGap = 0; holdErr = 0;
    validCnt = 0; validCyc = -1; macOut = -1; doneCnt = 0; doneCyc = -1; busyCnt = 0;
    timedOut = 1;
    addrQ.delete();
    cyc = 0; trail = 0; stallLeft = 0; acc = 0; lastIn = 0; lastWt = 0;
    prevRd = 1'b0; seenDone = 1'b0;
    @(posedge clk); #1;
    driveJob(selB, 1'b1, len, base);
    driveStall(1'b0);
    while (cyc < 300) begin
      @(negedge clk);
      rd   = selB ? ifB.buf_rd_o     : ifA.buf_rd_o;
      en   = selB ? ifB.dsp_enable_o : ifA.dsp_enable_o;
      clr  = selB ? ifB.clear_o      : ifA.clear_o;
      val  = selB ? ifB.dsp_valid_o  : ifA.dsp_valid_o;
      dn   = selB ? ifB.done_o       : ifA.done_o;
      bsy  = selB ? ifB.busy_o       : ifA.busy_o;
      addr = selB ? int'(ifB.buf_addr_o)  : int'(ifA.buf_addr_o);
      inV  = selB ? int'(ifB.dsp_input_o) : int'(ifA.dsp_input_o);
      wtV  = selB ? int'(ifB.dsp_weight_o) : int'(ifA.dsp_weight_o);
      if (clr) begin
        clearCnt++;
        if (clearCyc < 0) clearCyc = cyc;
        acc = 0;
      end
      if (rd) begin
        rdCnt++;
        if (firstRd < 0) firstRd = cyc;
        lastRd = cyc;
        addrQ.push_back(addr);
        if (prevRd) rdB2B++;
        if (rdCnt == stallAfter) stallLeft = stallLen;
      end
      prevRd = rd;
      if (en) begin
        if (enCnt > 0 && (cyc - lastEn - 1) > maxGap) maxGap = cyc - lastEn - 1;
        enCnt++;
        if (firstEn < 0) firstEn = cyc;
        lastEn = cyc;
        lastIn = inV;
        lastWt = wtV;
        acc += inV * wtV;
      end else if (enCnt > 0 && (inV != lastIn || wtV != lastWt)) begin
        holdErr++;
      end
      if (val) begin
        validCnt++;
        validCyc = cyc;
        macOut = acc;
      end
      if (bsy) busyCnt++;
      if (seenDone) trail++;
      if (dn) begin
        doneCnt++;
        if (!seenDone) doneCyc = cyc;
        seenDone = 1'b1;
      end
      if (seenDone && trail >= 10) begin
        timedOut = 0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      driveJob(selB, (cyc == pulseAt), len + 3, base + 1);
      driveStall(stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
    end
    driveJob(selB, 1'b0, 0, 0);
    driveStall(1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reads, guard;
    rstn = 1'b0;
    driveJob(1'b0, 1'b0, 0, 0);
    driveJob(1'b1, 1'b0, 0, 0);
    driveStall(1'b0);
    for (int i = 0; i < 256; i++) begin
      inMem[i] = '0;
      wtMem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      inMem[i] = 8'(i + 1);
      wtMem[i] = 8'(i + 5);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctrl_a", int'({ifA.busy_o, ifA.clear_o, ifA.buf_rd_o, ifA.dsp_enable_o,
                                     ifA.dsp_valid_o, ifA.done_o}), 0);
    checkOutput("reset_ctrl_b", int'({ifB.busy_o, ifB.clear_o, ifB.buf_rd_o, ifB.dsp_enable_o,
                                     ifB.dsp_valid_o, ifB.done_o}), 0);
    checkOutput("reset_data_a", int'({ifA.buf_addr_o, ifA.dsp_input_o, ifA.dsp_weight_o}), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    $display("[TB] T1 len=4 base=0");
    applyStimulus(1'b0, 4, 0, 0, 0, -1);
    checkOutput("t1_timeout", timedOut, 0);
    checkOutput("t1_clear_cnt", clearCnt, 1);
    checkOutput("t1_clear_cyc", clearCyc, 1);
    checkOutput("t1_first_rd", firstRd, 2);
    checkOutput("t1_rd_cnt", rdCnt, 4);
    checkOutput("t1_addr3", addrAt(3), 3);
    checkOutput("t1_en_cnt", enCnt, 4);
    checkOutput("t1_first_en", firstEn, 4);
    checkOutput("t1_en_gap", maxGap, 0);
    checkOutput("t1_valid_cyc", validCyc, 11);
    checkOutput("t1_valid_cnt", validCnt, 1);
    checkOutput("t1_mac", macOut, 70);
    checkOutput("t1_done_cnt", doneCnt, 1);
    checkOutput("t1_done_cyc", doneCyc, 11);
    checkOutput("t1_busy_cnt", busyCnt, 11);

    $display("[TB] T2 len=3 base=254 wrap");
    inMem[254] = 8'(-128); wtMem[254] = 8'(-128);
    inMem[255] = 8'(127);  wtMem[255] = 8'(-1);
    inMem[0]   = 8'(0);    wtMem[0]   = 8'(9);
    applyStimulus(1'b0, 3, 254, 0, 0, -1);
    checkOutput("t2_timeout", timedOut, 0);
    checkOutput("t2_addr0", addrAt(0), 254);
    checkOutput("t2_addr1", addrAt(1), 255);
    checkOutput("t2_addr2", addrAt(2), 0);
    checkOutput("t2_mac", macOut, 16257);
    checkOutput("t2_valid_cyc", validCyc, 10);

    $display("[TB] T3 len=5 unstalled then stalled");
    for (int i = 0; i < 5; i++) begin
      inMem[i] = 8'(i + 1);
      wtMem[i] = 8'(i + 5);
    end
    applyStimulus(1'b0, 5, 0, 0, 0, -1);
    checkOutput("t3a_mac", macOut, 115);
    checkOutput("t3a_valid_cyc", validCyc, 12);
    applyStimulus(1'b0, 5, 0, 2, 3, -1);
    checkOutput("t3b_timeout", timedOut, 0);
    checkOutput("t3b_rd_cnt", rdCnt, 5);
    checkOutput("t3b_en_cnt", enCnt, 5);
    checkOutput("t3b_en_gap", maxGap, 3);
    checkOutput("t3b_hold_err", holdErr, 0);
    checkOutput("t3b_mac", macOut, 115);
    checkOutput("t3b_valid_cyc", validCyc, 15);

    $display("[TB] T4 len=0");
    applyStimulus(1'b0, 0, 5, 0, 0, -1);
    checkOutput("t4_timeout", timedOut, 0);
    checkOutput("t4_clear_cnt", clearCnt, 1);
    checkOutput("t4_rd_cnt", rdCnt, 0);
    checkOutput("t4_en_cnt", enCnt, 0);
    checkOutput("t4_valid_cnt", validCnt, 0);
    checkOutput("t4_done_cnt", doneCnt, 1);
    checkOutput("t4_done_cyc", doneCyc, 2);
    checkOutput("t4_busy_cnt", busyCnt, 2);

    $display("[TB] T5 ACC_II=2 len=4 with start pulse while busy");
    applyStimulus(1'b1, 4, 0, 0, 0, 5);
    checkOutput("t5_timeout", timedOut, 0);
    checkOutput("t5_rd_cnt", rdCnt, 4);
    checkOutput("t5_first_rd", firstRd, 2);
    checkOutput("t5_last_rd", lastRd, 8);
    checkOutput("t5_rd_b2b", rdB2B, 0);
    checkOutput("t5_last_en", lastEn, 10);
    checkOutput("t5_valid_cyc", validCyc, 14);
    checkOutput("t5_mac", macOut, 70);
    checkOutput("t5_done_cnt", doneCnt, 1);
    checkOutput("t5_busy_cnt", busyCnt, 14);

    $display("[TB] T6 reset during issue");
    @(posedge clk); #1;
    driveJob(1'b0, 1'b1, 4, 0);
    @(posedge clk); #1;
    driveJob(1'b0, 1'b0, 4, 0);
    reads = 0;
    guard = 0;
    while (reads < 2 && guard < 20) begin
      @(negedge clk);
      if (ifA.buf_rd_o) reads++;
      guard++;
    end
    checkOutput("t6_reads_seen", reads, 2);
    @(negedge clk);
    checkOutput("t6_pre_enable", int'(ifA.dsp_enable_o), 1);
    rstn = 1'b0;
    #1;
    checkOutput("t6_ctrl_zero", int'({ifA.busy_o, ifA.clear_o, ifA.buf_rd_o, ifA.dsp_enable_o,
                                     ifA.dsp_valid_o, ifA.done_o}), 0);
    checkOutput("t6_addr_zero", int'(ifA.buf_addr_o), 0);
    checkOutput("t6_data_zero", int'({ifA.dsp_input_o, ifA.dsp_weight_o}), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    guard = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifA.dsp_valid_o || ifA.done_o || ifA.busy_o) guard++;
    end
    checkOutput("t6_quiet_after_reset", guard, 0);
    applyStimulus(1'b0, 4, 0, 0, 0, -1);
    checkOutput("t6_rerun_mac", macOut, 70);
    checkOutput("t6_rerun_valid_cyc", validCyc, 11);
    checkOutput("t6_rerun_done_cnt", doneCnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
